// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word loads and stores on a word array (DMEM_RESET_CLEAR_EN zeroes memory in reset).
// Latency: WAIT_CYCLES+1 cycles from accept to rsp_valid; one request in flight.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        accept;
    logic        enter_resp;
    logic        use_live;
    logic        acc_we;
    logic [1:0]  acc_size;
    logic        acc_unsigned;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_err;
    logic [1:0]  lane;
    logic [IDX_W-1:0] acc_idx;
    logic [3:0]  acc_be;
    logic [31:0] wr_lanes;
    logic [31:0] rd_word;
    logic [31:0] merged_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = req_valid & req_ready;

    // With zero wait the access happens on the accept edge, so it must use the live request.
    assign enter_resp = ~rst & (((state == WAIT) && (cnt == 4'd0)) ||
                                ((state == IDLE) && accept && (WAIT_CYCLES == 0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) & ~rst;
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 4'd0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
        end else if (accept) begin
            cnt          <= WAIT_LOAD;
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign use_live     = (state == IDLE);
    assign acc_we       = use_live ? req_we       : lat_we;
    assign acc_size     = use_live ? req_size     : lat_size;
    assign acc_unsigned = use_live ? req_unsigned : lat_unsigned;
    assign acc_addr     = use_live ? req_addr     : lat_addr;
    assign acc_wdata    = use_live ? req_wdata    : lat_wdata;
    assign lane         = acc_addr[1:0];
    assign acc_idx      = acc_addr[IDX_W+1:2];

    always_comb begin
        acc_err = 1'b0;
        case (acc_size)
            SZ_BYTE: acc_err = 1'b0;
            SZ_HALF: acc_err = acc_addr[0];
            SZ_WORD: acc_err = |acc_addr[1:0];
            default: acc_err = 1'b1;
        endcase
        if ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            acc_err = 1'b1;
        end
    end

    // Out-of-range indices only occur with acc_err set, which blocks use of rd_word.
    assign rd_word = mem[acc_idx];

    always_comb begin
        acc_be   = 4'b0000;
        wr_lanes = acc_wdata;
        case (acc_size)
            SZ_BYTE: begin
                acc_be   = 4'b0001 << lane;
                wr_lanes = {4{acc_wdata[7:0]}};
            end
            SZ_HALF: begin
                acc_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{acc_wdata[15:0]}};
            end
            SZ_WORD: begin
                acc_be   = 4'b1111;
                wr_lanes = acc_wdata;
            end
            default: acc_be = 4'b0000;
        endcase
        merged_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) merged_word[b*8 +: 8] = wr_lanes[b*8 +: 8];
        end
    end

    always_comb begin
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = 32'd0;
        case (acc_size)
            SZ_BYTE: ld_data = acc_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = acc_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            SZ_WORD: ld_data = rd_word;
            default: ld_data = 32'd0;
        endcase
    end

    assign mem_we = enter_resp & acc_we & ~acc_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err | acc_we) ? 32'd0 : ld_data;
        end
    end

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem[w] <= 32'd0;
            end
        end else if (mem_we) begin
            mem[acc_idx] <= merged_word;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= merged_word;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    assign m_req_ready = sel ? req_ready0 : req_ready1;
    assign m_rsp_valid = sel ? rsp_valid0 : rsp_valid1;
    assign m_rsp_err   = sel ? rsp_err0   : rsp_err1;
    assign m_rsp_rdata = sel ? rsp_rdata0 : rsp_rdata1;

    data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(req_ready1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(req_ready0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the request inputs while busy, check the response, then handshake.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int          n;
        int          lat_exp;
        logic [32:0] e;
        lat_exp = sel ? 1 : 2;
        n = 0;
        while (!m_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_idle", 32'(m_req_ready), 32'd1);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        exp_q.push_back({exp_err, exp_rdata});
        @(posedge clk); #1;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = {22'd0, 8'($urandom), 2'b00}; req_wdata = $urandom;
        n = 0;
        while (!m_rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_valid_seen", 32'(m_rsp_valid), 32'd1);
        chk("latency", 32'(n + 1), 32'(lat_exp));
        e = exp_q.pop_front();
        chk("rsp_rdata", m_rsp_rdata, e[31:0]);
        chk("rsp_err", 32'(m_rsp_err), 32'(e[32]));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(m_rsp_valid), 32'd1);
            chk("hold_rdata", m_rsp_rdata, e[31:0]);
            chk("hold_err", 32'(m_rsp_err), 32'(e[32]));
            chk("hold_req_ready", 32'(m_req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(m_rsp_valid), 32'd0);
        chk("req_ready_back", 32'(m_req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] e;
        logic [31:0] exp30;
        int          seen;
        sel = 1'b0; rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(m_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(m_rsp_err), 32'd0);
        chk("rst_rsp_rdata", m_rsp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_req_ready", 32'(m_req_ready), 32'd1);

        do_req(1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0);
        do_req(1'b1, 2'b00, 1'b0, 32'h11,  32'h0000005A, 32'h0,        1'b0, 0);
        do_req(1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0, 0);
        do_req(1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        32'h00005AEF, 1'b0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD5AEF, 1'b0, 0);
        do_req(1'b1, 2'b10, 1'b0, 32'h20,  32'h12345678, 32'h0,        1'b0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 0);
        do_req(1'b1, 2'b01, 1'b0, 32'h21,  32'h0000FFFF, 32'h0,        1'b1, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h12345678, 1'b0, 0);
        do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h80007F01, 32'h0,        1'b0, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0,        32'hFFFF8000, 1'b0, 0);
        do_req(1'b0, 2'b00, 1'b1, 32'h3FD, 32'h0,        32'h0000007F, 1'b0, 0);
        do_req(1'b1, 2'b01, 1'b0, 32'h3FE, 32'h0000ABCD, 32'h0,        1'b0, 0);
        do_req(1'b0, 2'b10, 1'b1, 32'h3FC, 32'h0,        32'hABCD7F01, 1'b0, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0,        32'hFFFFABCD, 1'b0, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 3);
        do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h1,        32'h0,        1'b1, 0);
        do_req(1'b1, 2'b10, 1'b0, 32'h30,  32'hCAFEF00D, 32'h0,        1'b0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD5AEF, 1'b0, 0);

        // Reset lands while a store to 0x30 sits in WAIT.
        chk("pre_rst_ready", 32'(m_req_ready), 32'd1);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h11111111; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("in_wait_no_rsp", 32'(m_rsp_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(m_req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("mid_rst_rsp_err", 32'(m_rsp_err), 32'd0);
        chk("mid_rst_rsp_rdata", m_rsp_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(m_req_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (m_rsp_valid) seen++;
        end
        chk("no_rsp_after_rst", 32'(seen), 32'd0);
`ifdef DMEM_RESET_CLEAR_EN
        exp30 = 32'h0;
`else
        exp30 = 32'hCAFEF00D;
`endif
        do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, exp30, 1'b0, 0);

        // Zero-wait instance: back-to-back store then load with rsp_ready held high.
        sel = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("wc0_ready", 32'(m_req_ready), 32'd1);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0BADCAFE; req_valid = 1'b1;
        exp_q.push_back({1'b0, 32'h0});
        @(posedge clk); #1;
        chk("wc0_st_lat1", 32'(m_rsp_valid), 32'd1);
        chk("wc0_st_busy", 32'(m_req_ready), 32'd0);
        e = exp_q.pop_front();
        chk("wc0_st_rdata", m_rsp_rdata, e[31:0]);
        chk("wc0_st_err", 32'(m_rsp_err), 32'(e[32]));
        req_we = 1'b0; req_wdata = 32'h0;
        exp_q.push_back({1'b0, 32'h0BADCAFE});
        @(posedge clk); #1;
        chk("wc0_gap_valid", 32'(m_rsp_valid), 32'd0);
        chk("wc0_gap_ready", 32'(m_req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wc0_ld_lat1", 32'(m_rsp_valid), 32'd1);
        e = exp_q.pop_front();
        chk("wc0_ld_rdata", m_rsp_rdata, e[31:0]);
        chk("wc0_ld_err", 32'(m_rsp_err), 32'(e[32]));
        @(posedge clk); #1;
        chk("wc0_done", 32'(m_rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 1, extra access latency in cycles (legal 0..15).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port req_valid  input  1  request present.
REQ-006 SHALL provide port req_ready  output  1  controller can accept a request.
REQ-007 SHALL provide port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL provide port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL provide port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL provide port req_addr  input  32  byte address.
REQ-011 SHALL provide port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL provide port rsp_valid  output  1  response present.
REQ-013 SHALL provide port rsp_ready  input  1  consumer accepts the response.
REQ-014 SHALL provide port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL provide port rsp_err  output  1  access faulted; qualified by rsp_valid.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a cycle with req_valid & req_ready, latching we/size/unsigned/addr/wdata.
REQ-018 SHALL, on accept, go to WAIT with cycle counter loaded to WAIT_CYCLES-1 when WAIT_CYCLES>0, else go directly to RESP.
REQ-019 SHALL decrement the counter each cycle in WAIT and move to RESP on the cycle the counter is 0.
REQ-020 SHALL perform the memory access (write commit, read capture) on the clock edge entering RESP.
REQ-021 SHALL hold rsp_valid = 1 and stable rsp_rdata/rsp_err in RESP until rsp_valid & rsp_ready, then return to IDLE.
REQ-022 SHALL give accept-to-first-rsp_valid latency of WAIT_CYCLES+1 cycles; back-to-back requests accepted no sooner than the cycle after response handshake.
REQ-023 SHALL form word index = addr[31:2], byte lane = addr[1:0].
REQ-024 SHALL flag error when size = 11, half with addr[0] = 1, word with addr[1:0] != 0, or word index >= DEPTH_WORDS.
REQ-025 SHALL, on error, leave memory unchanged and return rsp_rdata = 0, rsp_err = 1.
REQ-026 SHALL, on legal store, update only the addressed byte lanes (byte: 1 lane, half: lanes addr[1]*2..+1, word: all 4).
REQ-027 SHALL, on legal load, select the addressed lanes and sign- or zero-extend to 32 bits per req_unsigned; word ignores req_unsigned.
REQ-028 SHALL ignore req_valid and all request inputs while not in IDLE.

Reset
REQ-029 SHALL, while rst = 1, force state IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, req_ready 0 during reset then 1 after release.
REQ-030 SHALL abort any in-flight request on reset: no memory write is committed and no response is issued.

Configuration
REQ-031 SHALL, with macro DMEM_RESET_CLEAR_EN defined, clear every memory word to 0 while rst = 1.
REQ-032 SHALL, without DMEM_RESET_CLEAR_EN, leave memory contents untouched by reset (pre-load/power-up contents retained).

Verification
REQ-033 SHALL cover: WAIT_CYCLES=1, store word 0xDEADBEEF @0x10 then load word @0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after each accept.
REQ-034 SHALL cover: after REQ-033 data, store byte 0x5A @0x11, load signed byte @0x13 -> 0xFFFFFFDE; load unsigned half @0x10 -> 0x00005AEF.
REQ-035 SHALL cover: load word @0x12 and store half @0x21 -> rsp_err 1, rsp_rdata 0, memory @0x20 unchanged.
REQ-036 SHALL cover: DEPTH_WORDS=256, load word @0x400 -> rsp_err 1; rsp_ready held 0 for 3 cycles -> rsp_valid/rsp_err stable, req_ready 0 throughout.
REQ-037 SHALL cover: WAIT_CYCLES=0 back-to-back store/load with rsp_ready=1 -> response 1 cycle after each accept, one accept every 2 cycles.
REQ-038 SHALL cover: rst asserted mid-WAIT of a store to @0x30 -> no response, @0x30 unchanged (zero with DMEM_RESET_CLEAR_EN), req_ready 1 after release.
